// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the instruction-fetch stage of the 16-bit pipelined
// processor: default datapath widths, opcode / J-type func encodings seen in
// the IF/ID instruction word, and the fetch FSM state type.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 16;

    // Opcode field instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_JTYPE = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ADDI  = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_FOR   = 4'b1000;

    // J-type func field instr[2:0]
    localparam logic [2:0] FN_JMP  = 3'b000;
    localparam logic [2:0] FN_CALL = 3'b001;
    localparam logic [2:0] FN_RET  = 3'b010;

    // FETCH: ready to issue   WAIT: one request outstanding
    // HOLD : response parked  DROP: outstanding response is stale
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// -----------------------------------------------------------------------------
// next_pc_mux
// Combinational redirect arbitration for the fetch stage. A taken branch comes
// from execute and is older than anything decode reports, so it wins; RET is
// preferred over JMP/CALL when decode raises both.
//
// Ports:
//   branch_taken, branch_target : execute-stage taken branch
//   ret_en, rr_value            : decode-stage RET and return-register value
//   jmp_en, jmp_target          : decode-stage JMP/CALL
//   redirect                    : any redirect this cycle
//   target                      : selected new PC (meaningful when redirect=1)
// -----------------------------------------------------------------------------
module next_pc_mux
    import fetch_stage_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            ret_en,
    input  logic [PC_W-1:0] rr_value,
    input  logic            jmp_en,
    input  logic [PC_W-1:0] jmp_target,
    output logic            redirect,
    output logic [PC_W-1:0] target
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first); a missed path would infer a latch.
        redirect = branch_taken | ret_en | jmp_en;
        target   = jmp_target;
        if (branch_taken) begin
            target = branch_target;
        end else if (ret_en) begin
            target = rr_value;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Owns the PC, issues one outstanding request at a
// time to instruction memory, applies redirects and stalls, and drives the
// IF/ID pipeline register consumed by the decode-stage controller.
//
// Optional build macro: FETCH_STAT_EN adds saturating fetch/flush counters.
//
// Ports:
//   clk, reset                   : clock; asynchronous active-high reset
//   stall                        : hazard unit hold of IF/ID and PC
//   jmp_en/jmp_target            : decode JMP/CALL redirect
//   ret_en/rr_value              : decode RET redirect
//   branch_taken/branch_target   : execute taken-branch redirect
//   imem_req/imem_addr           : one-cycle request pulse and address
//   imem_valid/imem_rdata        : memory response
//   ifid_valid/ifid_instr        : IF/ID live flag and instruction
//   ifid_pc_next                 : PC+1 of the IF/ID instruction
//   stat_fetched/stat_flushed    : (FETCH_STAT_EN only) event counters
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                 PC_W     = PC_W_DEF,
    parameter int                 INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jmp_en,
    input  logic [PC_W-1:0]    jmp_target,
    input  logic               ret_en,
    input  logic [PC_W-1:0]    rr_value,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc_next
`ifdef FETCH_STAT_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_flushed
`endif
);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               imem_req_q, imem_req_d;
    logic [PC_W-1:0]    imem_addr_q, imem_addr_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_next_q, ifid_pc_next_d;
    // Hold buffer contents; the buffer is full exactly when state_q == HOLD.
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    // Set once a request has gone out since reset; responses seen in FETCH
    // before that are leftovers from a request killed by reset.
    logic               req_seen_q, req_seen_d;

    logic               redirect;
    logic [PC_W-1:0]    target;
    logic               ifid_load;
    logic [INSTR_W-1:0] load_instr;
    logic [PC_W-1:0]    pc_plus1;

    next_pc_mux #(.PC_W(PC_W)) u_next_pc_mux (
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ret_en        (ret_en),
        .rr_value      (rr_value),
        .jmp_en        (jmp_en),
        .jmp_target    (jmp_target),
        .redirect      (redirect),
        .target        (target)
    );

    // Width-preserving add: 'hFFFF wraps to 'h0000.
    assign pc_plus1 = pc_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        imem_req_d     = 1'b0;
        imem_addr_d    = imem_addr_q;
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_next_d = ifid_pc_next_q;
        hold_instr_d   = hold_instr_q;
        req_seen_d     = req_seen_q;
        ifid_load      = 1'b0;
        load_instr     = imem_rdata;

        // A redirect overrides stall in every state: new PC, flush IF/ID.
        if (redirect) begin
            pc_d         = target;
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            FETCH: begin
                if (!redirect && !stall) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    req_seen_d  = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    // Response already here is discarded; otherwise wait it out.
                    state_d = imem_valid ? FETCH : DROP;
                end else if (imem_valid) begin
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        state_d      = HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        load_instr = imem_rdata;
                        state_d    = FETCH;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    ifid_load  = 1'b1;
                    load_instr = hold_instr_q;
                    state_d    = FETCH;
                end
            end
            DROP: begin
                if (imem_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (ifid_load) begin
            ifid_valid_d   = 1'b1;
            ifid_instr_d   = load_instr;
            ifid_pc_next_d = pc_plus1;
            pc_d           = pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= FETCH;
            pc_q           <= RESET_PC;
            imem_req_q     <= 1'b0;
            imem_addr_q    <= RESET_PC;
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= '0;
            ifid_pc_next_q <= '0;
            // NOTE: the hold buffer is a single register, not a memory array,
            // so it is reset along with the rest for deterministic outputs.
            hold_instr_q   <= '0;
            req_seen_q     <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignment so every flop
            // samples the pre-edge values computed above.
            state_q        <= state_d;
            pc_q           <= pc_d;
            imem_req_q     <= imem_req_d;
            imem_addr_q    <= imem_addr_d;
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_next_q <= ifid_pc_next_d;
            hold_instr_q   <= hold_instr_d;
            req_seen_q     <= req_seen_d;
        end
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign ifid_valid   = ifid_valid_q;
    assign ifid_instr   = ifid_instr_q;
    assign ifid_pc_next = ifid_pc_next_q;

`ifdef FETCH_STAT_EN
    logic [31:0] stat_fetched_q;
    logic [31:0] stat_flushed_q;
    logic        flush_event;

    // A flush is a redirect that kills a live IF/ID entry, or any response
    // that is thrown away (discarded in WAIT/HOLD, or dropped in DROP).
    always_comb begin
        flush_event = (redirect && (ifid_valid_q || state_q == HOLD ||
                                    (state_q == WAIT && imem_valid))) ||
                      (state_q == DROP && imem_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_fetched_q <= '0;
            stat_flushed_q <= '0;
        end else begin
            if (ifid_load && stat_fetched_q != '1) begin
                stat_fetched_q <= stat_fetched_q + 1'b1;
            end
            if (flush_event && stat_flushed_q != '1) begin
                stat_flushed_q <= stat_flushed_q + 1'b1;
            end
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushed = stat_flushed_q;
`endif

    // imem_valid is only legal with a request outstanding (WAIT/DROP).
    // Stale responses between reset release and the first request are allowed.
    a_imem_valid_protocol: assert property (@(posedge clk) disable iff (reset)
        !(imem_valid && (state_q == HOLD || (state_q == FETCH && req_seen_q))));

endmodule
